// File: rtl/ad_lvds_pkg.sv
// Shared ad_lvds definitions: FSM state encodings and the default alignment word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ad_lvds_pkg;

    // Alignment FSM states; the encodings are fixed so the serializer-side model can share them.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lvds_state_t;

    // Default alignment word: upper byte travels on lane 1, lower byte on lane 0.
    localparam logic [15:0] AD_LVDS_SYNC_WORD_DEF = 16'hF00F;

    // Width of the per-lane shift register (one byte per word per lane).
    localparam int unsigned AD_LVDS_LANE_W = 8;

endpackage

// File: rtl/ad_lvds_lane_shift.sv
// One LVDS lane: 8-bit shift register, new bit enters the LSB (MSB-first serial order).
// Latency: one clk from lane bit to its appearance in sh[0].
// Backpressure: none; shifts unconditionally every edge.
module ad_lvds_lane_shift
    import ad_lvds_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [AD_LVDS_LANE_W-1:0] sh
);

    // Shift left every edge so the oldest bit ends up in the MSB after eight edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else begin
            sh <= {sh[AD_LVDS_LANE_W-2:0], din};
        end
    end

endmodule

// File: rtl/ad_lvds_deserializer.sv
// Two-lane LVDS deserializer: hunts for SYNC_WORD, verifies LOCK_CNT repeats, then strobes out words.
// Latency: strobe 2 clk after the last bit of a word is on the lanes.
// Backpressure: none; words are delivered as one-cycle strobes, downstream must accept every strobe.
module ad_lvds_deserializer
    import ad_lvds_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = AD_LVDS_SYNC_WORD_DEF,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dout0,
    input  logic        i_dout1,
    input  logic        i_align_req,
    output logic [15:0] ov_pix_data,
    output logic        o_pix_valid,
    output logic        o_sync_det,
    output logic        o_locked
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    logic [7:0]  sh0;
    logic [7:0]  sh1;
    logic [15:0] candidate;
    logic        cand_sync;
    logic        boundary;

    lvds_state_t state, state_nxt;
    logic [2:0]  phase, phase_nxt;
    logic [3:0]  match_cnt, match_nxt;
    logic [3:0]  match_inc;
    logic [15:0] data_nxt;
    logic        valid_nxt;
    logic        sync_det_nxt;

    ad_lvds_lane_shift u_lane0 (
        .clk   (clk),
        .reset (reset),
        .din   (i_dout0),
        .sh    (sh0)
    );

    ad_lvds_lane_shift u_lane1 (
        .clk   (clk),
        .reset (reset),
        .din   (i_dout1),
        .sh    (sh1)
    );

    assign candidate = {sh1, sh0};
    assign cand_sync = (candidate == SYNC_WORD);
    assign boundary  = (phase == 3'd0);
    assign match_inc = match_cnt + 4'd1;
    assign o_locked  = (state == LOCKED);

    // State, word phase, verify count and the registered output word/strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            phase       <= 3'd0;
            match_cnt   <= 4'd0;
            ov_pix_data <= 16'd0;
            o_pix_valid <= 1'b0;
            o_sync_det  <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            match_cnt   <= match_nxt;
            ov_pix_data <= data_nxt;
            o_pix_valid <= valid_nxt;
            o_sync_det  <= sync_det_nxt;
        end
    end

    // Alignment decisions; an align request overrides everything, including a due strobe.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        match_nxt    = match_cnt;
        data_nxt     = ov_pix_data;
        valid_nxt    = 1'b0;
        sync_det_nxt = 1'b0;

        if (i_align_req) begin
            state_nxt = HUNT;
            phase_nxt = 3'd0;
            match_nxt = 4'd0;
        end else begin
            case (state)
                HUNT: begin
                    phase_nxt = 3'd0;
                    if (cand_sync) begin
                        // The matching word ends here, so the next boundary is 8 edges away.
                        phase_nxt = 3'd1;
                        match_nxt = 4'd1;
                        if (LOCK_CNT == 1) begin
                            state_nxt = LOCKED;
                        end else begin
                            state_nxt = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    phase_nxt = phase + 3'd1;
                    if (boundary) begin
                        if (cand_sync) begin
                            match_nxt = match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            state_nxt = HUNT;
                            phase_nxt = 3'd0;
                            match_nxt = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    // No automatic loss of lock: only an align request or reset leaves this state.
                    phase_nxt = phase + 3'd1;
                    if (boundary) begin
                        data_nxt     = candidate;
                        valid_nxt    = 1'b1;
                        sync_det_nxt = cand_sync;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    phase_nxt = 3'd0;
                    match_nxt = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad_lvds_deserializer.sv
// Self-checking bench for ad_lvds_deserializer: scoreboarded word delivery, lock timing, align and reset.
// Latency: expects each strobe 9 edges after the word's first bit edge is scheduled.
// Backpressure: n/a.
module tb_ad_lvds_deserializer;
    import ad_lvds_pkg::*;

    localparam logic [15:0] SYNC = 16'hF00F;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_dout0;
    logic        i_dout1;
    logic        i_align_req;
    logic [15:0] ov_pix_data;
    logic        o_pix_valid;
    logic        o_sync_det;
    logic        o_locked;

    typedef struct {
        logic [15:0] data;
        logic        sync;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_miss    = 0;
    int   cyc       = 0;
    int   last_rise = -1;
    int   last_fall = -1;
    logic locked_q  = 1'b0;

    ad_lvds_deserializer #(
        .SYNC_WORD (SYNC),
        .LOCK_CNT  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_dout0     (i_dout0),
        .i_dout1     (i_dout1),
        .i_align_req (i_align_req),
        .ov_pix_data (ov_pix_data),
        .o_pix_valid (o_pix_valid),
        .o_sync_det  (o_sync_det),
        .o_locked    (o_locked)
    );

    always #5 clk = ~clk;

    // Drive one bit per lane for one edge, then monitor outputs at the following negedge.
    task automatic drive_bit(input logic b1, input logic b0, input logic align = 1'b0);
        exp_t e;
        i_dout1     = b1;
        i_dout0     = b0;
        i_align_req = align;
        @(posedge clk);
        @(negedge clk);
        i_align_req = 1'b0;
        cyc++;
        if (o_locked && !locked_q) last_rise = cyc;
        if (!o_locked && locked_q) last_fall = cyc;
        locked_q = o_locked;
        if (o_pix_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_strobe: got data=%h sync_det=%b at cycle %0d, required no strobe",
                         ov_pix_data, o_sync_det, cyc);
            end else begin
                e = sb.pop_front();
                if (ov_pix_data !== e.data || o_sync_det !== e.sync || cyc != e.at) begin
                    n_miss++;
                    $display("FAIL strobe_word: got data=%h sync_det=%b cycle=%0d, required data=%h sync_det=%b cycle=%0d",
                             ov_pix_data, o_sync_det, cyc, e.data, e.sync, e.at);
                end
            end
        end
    endtask

    // Serialize one word MSB first, optionally scheduling it on the scoreboard.
    task automatic send_word(input logic [15:0] w, input bit push, input bit align_first = 1'b0);
        exp_t e;
        if (push) begin
            e.data = w;
            e.sync = (w == SYNC);
            e.at   = cyc + 9;
            sb.push_back(e);
        end
        for (int b = 7; b >= 0; b--) begin
            drive_bit(w[8+b], w[b], align_first && (b == 7));
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        i_dout0     = 1'b0;
        i_dout1     = 1'b0;
        i_align_req = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        locked_q = 1'b0;
    endtask

    // Let the last scheduled strobe drain, then make sure nothing is left outstanding.
    task automatic end_scenario(input string name);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s_drain: got %0d undelivered words, required 0", name, sb.size());
        end
    endtask

    task automatic check_rise(input string name, input int expected);
        n_vec++;
        if (last_rise != expected) begin
            n_miss++;
            $display("FAIL %s_lock_rise: got cycle %0d, required cycle %0d", name, last_rise, expected);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        i_dout0     = 1'b1;
        i_dout1     = 1'b1;
        i_align_req = 1'b0;
        #1;
        n_vec++;
        if ({ov_pix_data, o_pix_valid, o_sync_det, o_locked} !== 19'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got data=%h valid=%b sync=%b locked=%b, required all 0",
                     ov_pix_data, o_pix_valid, o_sync_det, o_locked);
        end
        do_reset();
    endtask

    task automatic test_basic_lock();
        int e;
        do_reset();
        repeat (4) send_word(SYNC, 1'b0);
        e = cyc;
        send_word(SYNC, 1'b1);
        check_rise("basic", e + 1);
        send_word(16'h1234, 1'b1);
        send_word(16'hABCD, 1'b1);
        end_scenario("basic");
    endtask

    task automatic test_offsets();
        int e;
        logic [15:0] rw;
        for (int off = 0; off < 8; off++) begin
            do_reset();
            for (int k = 0; k < off; k++) drive_bit(1'b0, 1'b0);
            repeat (4) send_word(SYNC, 1'b0);
            e  = cyc;
            rw = 16'($urandom);
            send_word(SYNC, 1'b1);
            check_rise("offset", e + 1);
            send_word(rw, 1'b1);
            end_scenario("offset");
        end
    endtask

    task automatic test_verify_abort();
        int e;
        do_reset();
        send_word(SYNC, 1'b0);
        send_word(SYNC, 1'b0);
        send_word(16'h0000, 1'b0);
        drive_bit(1'b1, 1'b0);
        n_vec++;
        if (o_locked !== 1'b0) begin
            n_miss++;
            $display("FAIL verify_abort_locked: got %b, required 0", o_locked);
        end
        do_reset();
        send_word(SYNC, 1'b0);
        send_word(SYNC, 1'b0);
        send_word(16'h0000, 1'b0);
        repeat (3) send_word(SYNC, 1'b0);
        n_vec++;
        if (o_locked !== 1'b0) begin
            n_miss++;
            $display("FAIL verify_abort_early_lock: got %b, required 0", o_locked);
        end
        send_word(SYNC, 1'b0);
        e = cyc;
        send_word(16'h5A5A, 1'b1);
        check_rise("verify_abort", e + 1);
        end_scenario("verify_abort");
    endtask

    task automatic test_align_req();
        int e;
        do_reset();
        repeat (4) send_word(SYNC, 1'b0);
        send_word(16'h1234, 1'b1);
        send_word(16'h5678, 1'b0);
        e = cyc;
        send_word(SYNC, 1'b0, 1'b1);
        n_vec++;
        if (last_fall != e + 1) begin
            n_miss++;
            $display("FAIL align_lock_fall: got cycle %0d, required cycle %0d", last_fall, e + 1);
        end
        n_vec++;
        if (o_locked !== 1'b0) begin
            n_miss++;
            $display("FAIL align_locked_after: got %b, required 0", o_locked);
        end
        repeat (3) send_word(SYNC, 1'b0);
        e = cyc;
        send_word(16'h9ABC, 1'b1);
        check_rise("align_relock", e + 1);
        end_scenario("align");
    endtask

    task automatic test_async_reset();
        int e;
        do_reset();
        repeat (4) send_word(SYNC, 1'b0);
        send_word(16'h1111, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({ov_pix_data, o_pix_valid, o_sync_det, o_locked} !== 19'd0) begin
            n_miss++;
            $display("FAIL async_reset_outputs: got data=%h valid=%b sync=%b locked=%b, required all 0",
                     ov_pix_data, o_pix_valid, o_sync_det, o_locked);
        end
        sb.delete();
        @(negedge clk);
        reset    = 1'b0;
        locked_q = 1'b0;
        repeat (4) send_word(SYNC, 1'b0);
        e = cyc;
        send_word(16'hACE1, 1'b1);
        check_rise("async_relock", e + 1);
        send_word(SYNC, 1'b1);
        end_scenario("async_reset");
    endtask

    task automatic test_false_sync();
        do_reset();
        repeat (4) begin
            send_word(16'h0FF0, 1'b0);
            send_word(16'h0000, 1'b0);
            n_vec++;
            if (o_locked !== 1'b0) begin
                n_miss++;
                $display("FAIL false_sync_locked: got %b, required 0", o_locked);
            end
        end
        end_scenario("false_sync");
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_offsets();
        test_verify_abort();
        test_align_req();
        test_async_reset();
        test_false_sync();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ad_lvds_deserializer.md
AD_LVDS_DESERIALIZER -- requirements
Module: ad_lvds_deserializer

Interface
REQ-001 Parameter SYNC_WORD, default 16'hF00F, meaning the alignment word: bits [15:8] on lane 1, bits [7:0] on lane 0.
REQ-002 Parameter LOCK_CNT, default 4, meaning the number of consecutive SYNC_WORD words (range 1..15) required to declare lock.
REQ-003 clk  input  1  bit clock, one lane bit per rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_dout0  input  1  lane 0 serial data, MSB first.
REQ-006 i_dout1  input  1  lane 1 serial data, MSB first.
REQ-007 i_align_req  input  1  single-cycle request to restart alignment.
REQ-008 ov_pix_data  output  16  recovered pixel word, {lane1 byte, lane0 byte}.
REQ-009 o_pix_valid  output  1  one-cycle strobe qualifying ov_pix_data.
REQ-010 o_sync_det  output  1  one-cycle strobe; the word delivered while locked equals SYNC_WORD.
REQ-011 o_locked  output  1  high while in state LOCKED.

Function
REQ-012 Every rising edge SHALL shift each lane register left and insert the new bit in the LSB: sh0<={sh0[6:0],i_dout0}, sh1<={sh1[6:0],i_dout1}.
REQ-013 The candidate word SHALL be {sh1,sh0}, taken from the register values in the current cycle.
REQ-014 The block SHALL run a state machine with states HUNT, VERIFY and LOCKED; reset enters HUNT.
REQ-015 HUNT, candidate equals SYNC_WORD: the 3-bit phase counter SHALL be set to 1. If LOCK_CNT=1 the next state is LOCKED, otherwise VERIFY with match_cnt=1.
REQ-016 The phase counter SHALL increment modulo 8 in VERIFY and in LOCKED. A word boundary is any cycle in which the phase counter equals 0, i.e. exactly 8 cycles after the previous boundary or after the HUNT match.
REQ-017 VERIFY, at a boundary, candidate equals SYNC_WORD: match_cnt SHALL increment. When it reaches LOCK_CNT the next state is LOCKED.
REQ-018 VERIFY, at a boundary, candidate differs from SYNC_WORD: the next state SHALL be HUNT with match_cnt=0.
REQ-019 LOCKED, at each boundary: ov_pix_data<=candidate and o_pix_valid=1 for exactly one cycle. Latency from the last bit on the lanes to the strobe is 2 clk.
REQ-020 LOCKED, when the delivered word equals SYNC_WORD: o_sync_det SHALL pulse coincident with o_pix_valid. The word is still delivered as data.
REQ-021 LOCKED SHALL be left only through i_align_req or reset. There is no automatic loss-of-lock.
REQ-022 i_align_req=1 in any state SHALL force HUNT and clear match_cnt on the next edge; o_locked falls in the same edge. A strobe scheduled for that cycle SHALL be suppressed.
REQ-023 i_align_req takes priority over a simultaneous sync match or boundary.
REQ-024 ov_pix_data SHALL hold its last value outside strobes; o_pix_valid and o_sync_det are 0 outside LOCKED.
REQ-025 Unaligned data in HUNT SHALL produce no output strobes.

Reset
REQ-026 Asserting reset SHALL asynchronously clear sh0, sh1, phase counter, match_cnt, ov_pix_data, o_pix_valid, o_sync_det and o_locked to 0, and set the state to HUNT.
REQ-027 Reset mid-word or while LOCKED SHALL discard partial data. Alignment restarts from HUNT on the first edge after deassertion.

Structure
REQ-028 State encodings (HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2) and the default SYNC_WORD SHALL live in the shared ad_lvds definitions header used by the serializer-side model.
REQ-029 The per-lane 8-bit shift register SHALL be one sub-module, ad_lvds_lane_shift, instantiated twice. Everything else is flat.

Verification
REQ-030 Case: the upstream serializer model drives 5 words of 16'hF00F, then 16'h1234, 16'hABCD (LOCK_CNT=4). Required: o_locked rises at the 4th sync boundary; strobes deliver F00F (o_sync_det=1), then 1234, then ABCD (o_sync_det=0).
REQ-031 Case: start the stream at a random bit offset 0..7. Required: lock and correct data for all 8 offsets; no strobe before lock.
REQ-032 Case: sequence F00F, F00F, 0000 during VERIFY. Required: returns to HUNT, o_locked stays 0, then relocks on 4 further syncs.
REQ-033 Case: pulse i_align_req while LOCKED. Required: o_locked=0 the next cycle, the boundary strobe in that cycle is suppressed, and the block relocks after LOCK_CNT syncs.
REQ-034 Case: assert reset asynchronously mid-word while LOCKED. Required: all outputs are 0 immediately; after release the block relocks and data matches.
REQ-035 Case: data 16'h0FF0 (sync rotated by 4). Required: no false lock in HUNT.
